// File: rtl/seu_monitored_pipeline.sv
// Valid-qualified delay pipeline with stall/flush and an SEU event counter fed by voter mismatch flags.
// Optional feature: define SEU_COUNT_SATURATE_EN to saturate the counter and keep a sticky overflow flag.
module seu_monitored_pipeline #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned NSRC        = 3,
   parameter int unsigned SEUCNTWIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       d,
   input  logic                   d_valid,
   output logic [WIDTH-1:0]       q,
   output logic                   q_valid,
   input  logic [NSRC-1:0]        tmr_error,
   input  logic                   seu_cnt_clr,
   output logic [SEUCNTWIDTH-1:0] seu_count,
   output logic                   seu_overflow
);

   localparam int unsigned INCWIDTH = $clog2(NSRC + 1);
   localparam int unsigned SUMWIDTH = SEUCNTWIDTH + INCWIDTH;

   logic [WIDTH-1:0] stageData           [DEPTH];
   logic [WIDTH-1:0] stageDataNext       [DEPTH];
   logic [WIDTH-1:0] stageDataNextVoted  [DEPTH];
   logic [DEPTH-1:0] stageValid;
   logic [DEPTH-1:0] stageValidNext;
   logic [DEPTH-1:0] stageValidNextVoted;

   logic [INCWIDTH-1:0]    seuInc;
   logic [SUMWIDTH-1:0]    seuSum;
   logic [SEUCNTWIDTH-1:0] seuCountNext;
   logic [SEUCNTWIDTH-1:0] seuCountNextVoted;

   // Pipeline next state: data shifts on en, valid bits cleared by flush regardless of en
   always_comb begin
      stageDataNext  = stageData;
      stageValidNext = stageValid;
      if (en) begin
         stageDataNext[0]  = d;
         stageValidNext[0] = d_valid;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stageDataNext[i]  = stageData[i-1];
            stageValidNext[i] = stageValid[i-1];
         end
      end
      if (flush) begin
         stageValidNext = '0;
      end
   end

   // Voter insertion points for the triplication tool
   assign stageDataNextVoted  = stageDataNext;
   assign stageValidNextVoted = stageValidNext;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stageData[i] <= '0;
         end
         stageValid <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stageData[i] <= stageDataNextVoted[i];
         end
         stageValid <= stageValidNextVoted;
      end
   end

   assign q       = stageData[DEPTH-1];
   assign q_valid = stageValid[DEPTH-1];

   // Popcount of the voter mismatch flags
   always_comb begin
      seuInc = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         seuInc = seuInc + INCWIDTH'(tmr_error[i]);
      end
   end

   // Widened so a carry past the counter width is still visible
   assign seuSum = SUMWIDTH'(seu_count) + SUMWIDTH'(seuInc);

`ifdef SEU_COUNT_SATURATE_EN
   localparam logic [SUMWIDTH-1:0] CNTMAX = SUMWIDTH'({SEUCNTWIDTH{1'b1}});

   logic seuOverflowNext;

   always_comb begin
      seuCountNext    = SEUCNTWIDTH'(seuSum);
      seuOverflowNext = seu_overflow;
      if (seu_cnt_clr) begin
         seuCountNext    = '0;
         seuOverflowNext = 1'b0;
      end else if (seuSum > CNTMAX) begin
         seuCountNext    = '1;
         seuOverflowNext = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seu_overflow <= 1'b0;
      end else begin
         seu_overflow <= seuOverflowNext;
      end
   end
`else
   always_comb begin
      seuCountNext = SEUCNTWIDTH'(seuSum);
      if (seu_cnt_clr) begin
         seuCountNext = '0;
      end
   end

   assign seu_overflow = 1'b0;
`endif

   assign seuCountNextVoted = seuCountNext;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seu_count <= '0;
      end else begin
         seu_count <= seuCountNextVoted;
      end
   end

endmodule

// File: tb/tb_seu_monitored_pipeline.sv
// Directed bench for seu_monitored_pipeline (WIDTH=8, DEPTH=4, NSRC=3, SEUCNTWIDTH=8).
module tb_seu_monitored_pipeline;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       flush;
   logic [7:0] d;
   logic       d_valid;
   logic [7:0] q;
   logic       q_valid;
   logic [2:0] tmr_error;
   logic       seu_cnt_clr;
   logic [7:0] seu_count;
   logic       seu_overflow;

   int checks = 0;
   int errors = 0;

   seu_monitored_pipeline #(
      .WIDTH(8), .DEPTH(4), .NSRC(3), .SEUCNTWIDTH(8)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .flush(flush),
      .d(d), .d_valid(d_valid), .q(q), .q_valid(q_valid),
      .tmr_error(tmr_error), .seu_cnt_clr(seu_cnt_clr),
      .seu_count(seu_count), .seu_overflow(seu_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
      tmr_error = '0; seu_cnt_clr = 1'b0;
      #2;
      checkVal("rst_q", 32'(q), 32'h0);
      checkVal("rst_qv", 32'(q_valid), 32'h0);
      checkVal("rst_cnt", 32'(seu_count), 32'h0);
      checkVal("rst_ovf", 32'(seu_overflow), 32'h0);
      tick();
      rstn = 1'b1;
      tick();

      // 1: single word, 4 edges of latency
      en = 1'b1; d = 8'hA5; d_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         d = 8'h00; d_valid = 1'b0;
         checkVal($sformatf("t1_qv_e%0d", k), 32'(q_valid), 32'(k == 4));
         if (k == 4) checkVal("t1_q", 32'(q), 32'hA5);
      end

      // 2: stall three cycles mid-flight, word emerges 7 edges after entry
      d = 8'hA5; d_valid = 1'b1; en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         d = 8'h00; d_valid = 1'b0;
         en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
         checkVal($sformatf("t2_qv_e%0d", k), 32'(q_valid), 32'(k == 7));
         if (k == 7) checkVal("t2_q", 32'(q), 32'hA5);
      end

      // 3: fill four words, flush while stalled
      en = 1'b1; d_valid = 1'b1;
      d = 8'h11; tick();
      d = 8'h22; tick();
      d = 8'h33; tick();
      d = 8'h44; tick();
      checkVal("t3_full_q", 32'(q), 32'h11);
      checkVal("t3_full_qv", 32'(q_valid), 32'h1);
      en = 1'b0; flush = 1'b1; d = 8'h55;
      tick();
      flush = 1'b0; d = 8'h00; d_valid = 1'b0;
      checkVal("t3_flush_qv", 32'(q_valid), 32'h0);
      checkVal("t3_flush_q", 32'(q), 32'h11);
      en = 1'b1;
      begin
         logic [7:0] expQ [4];
         expQ = '{8'h22, 8'h33, 8'h44, 8'h00};
         for (int k = 0; k < 4; k++) begin
            tick();
            checkVal($sformatf("t3_qv_%0d", k), 32'(q_valid), 32'h0);
            checkVal($sformatf("t3_q_%0d", k), 32'(q), 32'(expQ[k]));
         end
      end

      // 4: two sources flagging for two cycles
      tmr_error = 3'b101;
      tick(); checkVal("t4_cnt1", 32'(seu_count), 32'd2);
      tick(); checkVal("t4_cnt2", 32'(seu_count), 32'd4);
      tmr_error = 3'b000;
      tick(); checkVal("t4_hold", 32'(seu_count), 32'd4);

      // 5: climb to 254, then add 3
      tmr_error = 3'b111;
      for (int k = 0; k < 83; k++) tick();
      tmr_error = 3'b001;
      tick();
      checkVal("t5_254", 32'(seu_count), 32'd254);
      tmr_error = 3'b111;
      tick();
`ifdef SEU_COUNT_SATURATE_EN
      checkVal("t5_sat", 32'(seu_count), 32'd255);
      checkVal("t5_ovf", 32'(seu_overflow), 32'h1);
      tmr_error = 3'b000;
      tick();
      checkVal("t5_hold", 32'(seu_count), 32'd255);
      checkVal("t5_sticky", 32'(seu_overflow), 32'h1);
`else
      checkVal("t5_wrap", 32'(seu_count), 32'd1);
      checkVal("t5_ovf", 32'(seu_overflow), 32'h0);
      tmr_error = 3'b000;
      tick();
      checkVal("t5_hold", 32'(seu_count), 32'd1);
`endif

      // 6: clear beats same-cycle errors
      seu_cnt_clr = 1'b1; tmr_error = 3'b111;
      tick();
      seu_cnt_clr = 1'b0;
      checkVal("t6_clr_cnt", 32'(seu_count), 32'd0);
      checkVal("t6_clr_ovf", 32'(seu_overflow), 32'h0);

      // Async reset mid-shift with count at 9
      en = 1'b1; d = 8'h5A; d_valid = 1'b1;
      tick(); tick();
      tick();
      tmr_error = 3'b000;
      tick();
      checkVal("t6_cnt9", 32'(seu_count), 32'd9);
      checkVal("t6_pre_q", 32'(q), 32'h5A);
      checkVal("t6_pre_qv", 32'(q_valid), 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      checkVal("t6_arst_q", 32'(q), 32'h0);
      checkVal("t6_arst_qv", 32'(q_valid), 32'h0);
      checkVal("t6_arst_cnt", 32'(seu_count), 32'h0);
      checkVal("t6_arst_ovf", 32'(seu_overflow), 32'h0);
      en = 1'b0; d_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      checkVal("t6_post_qv", 32'(q_valid), 32'h0);
      checkVal("t6_post_cnt", 32'(seu_count), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
